// File: rtl/rr_sel_arbiter4.sv
// Round-robin 4:1 packet arbiter: drives the downstream mux select and forwards
// the granted source's beats through one valid/ready output register.
module rr_sel_arbiter4 #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    input  logic [4*WIDTH-1:0] req_data,
    input  logic [3:0]         req_last,
    output logic [3:0]         req_ready,
    output logic [1:0]         sel,
    output logic               sel_valid,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               trunc_err
);
    localparam int CNT_W = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = (MAX_BEATS == 0) ? '0 : CNT_W'(MAX_BEATS - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] od_q, od_d;
    logic             ol_q, ol_d;
    logic             te_q, te_d;

    logic [WIDTH-1:0] src_data [4];
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;
    logic             granted;
    logic             can_take;
    logic             accept;
    logic             beat_last;
    logic             cut;

    for (genvar i = 0; i < 4; i++) begin : g_src
        assign src_data[i] = req_data[i*WIDTH +: WIDTH];
    end

    // First valid source at or after the pointer, wrapping modulo 4.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign granted   = (state_q == GRANT);
    assign can_take  = !ov_q || out_ready;
    assign accept    = granted && req_valid[sel_q] && can_take;
    assign beat_last = req_last[sel_q];
    assign cut       = (MAX_BEATS != 0) && (cnt_q == LAST_CNT) && !beat_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            te_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            te_q    <= te_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        te_d    = 1'b0;
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = winner;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    ov_d  = 1'b1;
                    od_d  = src_data[sel_q];
                    ol_d  = beat_last || cut;
                    cnt_d = cnt_q + CNT_W'(1);
                    // A truncated packet ends here; its leftover beats compete afresh.
                    if (beat_last || cut) begin
                        te_d    = cut;
                        ptr_d   = sel_q + 2'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (granted && can_take) begin
            req_ready[sel_q] = 1'b1;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = granted;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_last  = ol_q;
    assign trunc_err = te_q;

endmodule
